// File: rtl/video_pkg.sv
// Shared definitions for the video test-pattern path: mode count and the
// mode-switch sequencer state encoding.
package video_pkg;

  localparam int NUM_MODES = 8;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_FRAME  = 3'd1,
    BLANK_FRAME = 3'd2,
    APPLY       = 3'd3,
    SETTLE      = 3'd4
  } mode_seq_state_t;

endpackage

// File: rtl/frame_edge_detect.sv
// Single-cycle frame pulse on each inactive-to-active vsync transition,
// where "active" means vsync matches vsync_pol.
module frame_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic vsync,
  input  logic vsync_pol,
  output logic fp
);

  logic active;
  logic prev_active;

  assign active = (vsync == vsync_pol);

  // Resetting to "active" stops a pulse when reset releases mid-vsync.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_active <= 1'b1;
    end else begin
      prev_active <= active;
    end
  end

  assign fp = active && !prev_active;

endmodule

// File: rtl/mode_switch_controller.sv
// Sequences a video-mode change: waits for a frame boundary, blanks one full
// frame, applies the new config byte, then holds blank for SETTLE_FRAMES frames.
module mode_switch_controller #(
  parameter int NUM_MODES     = video_pkg::NUM_MODES,
  parameter int DEFAULT_MODE  = 0,
  parameter int SETTLE_FRAMES = 60
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       req_valid,
  input  logic [7:0]                 req_mode,
  output logic                       req_ready,
  input  logic                       vsync,
  input  logic                       vsync_pol,
  output logic [7:0]                 config_data,
  output logic                       blank,
  output logic                       trigger_enable,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output video_pkg::mode_seq_state_t seq_state
);

  import video_pkg::*;

  localparam int CNT_W = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(SETTLE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [7:0] DEFAULT_CFG = 8'(DEFAULT_MODE);

  mode_seq_state_t  state;
  logic [7:0]       pending_mode;
  logic [CNT_W-1:0] settle_cnt;
  logic [CNT_W-1:0] settle_next;
  logic             fp;
  logic             req_in_range;

  frame_edge_detect u_frame_edge_detect (
    .clock     (clock),
    .reset_n   (reset_n),
    .vsync     (vsync),
    .vsync_pol (vsync_pol),
    .fp        (fp)
  );

  assign settle_next  = (settle_cnt == CNT_MAX) ? settle_cnt : settle_cnt + CNT_W'(1);
  assign req_in_range = 32'(req_mode) < NUM_MODES;

  // A request transfers when req_valid && req_ready on a rising clock; ready
  // is high only in IDLE and requests seen in any other state are dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      config_data  <= DEFAULT_CFG;
      pending_mode <= DEFAULT_CFG;
      blank        <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      settle_cnt   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            if (!req_in_range) begin
              err <= 1'b1;
            end else if (req_mode == config_data) begin
              done <= 1'b1;
            end else begin
              pending_mode <= req_mode;
              state        <= WAIT_FRAME;
            end
          end
        end
        WAIT_FRAME: begin
          if (fp) begin
            blank <= 1'b1;
            state <= BLANK_FRAME;
          end
        end
        BLANK_FRAME: begin
          if (fp) begin
            state <= APPLY;
          end
        end
        APPLY: begin
          // Any fp landing in this cycle is deliberately not counted.
          config_data <= pending_mode;
          settle_cnt  <= '0;
          if (SETTLE_FRAMES == 0) begin
            blank <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (fp) begin
            settle_cnt <= settle_next;
            if (settle_next == CNT_TARGET) begin
              blank <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy           = (state != IDLE);
  assign req_ready      = (state == IDLE);
  assign trigger_enable = !blank && !busy;
  assign seq_state      = state;

endmodule

// File: tb/tb_mode_switch_controller.sv
// Bench for mode_switch_controller: two instances (SETTLE_FRAMES 2 and 0)
// checked every cycle against a frame-counting reference model.
module tb_mode_switch_controller;

  localparam int TB_NUM_MODES = 8;
  localparam int SETTLE[2] = '{2, 0};

  // clock / reset
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic       req_valid[2];
  logic [7:0] req_mode;
  logic       vsync;
  logic       vsync_pol;
  logic       req_ready[2];
  logic [7:0] config_data[2];
  logic       blank[2];
  logic       trigger_enable[2];
  logic       busy[2];
  logic       done[2];
  logic       err[2];
  video_pkg::mode_seq_state_t seq_state[2];

  mode_switch_controller #(.NUM_MODES(8), .DEFAULT_MODE(0), .SETTLE_FRAMES(2)) dut0 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid[0]), .req_mode(req_mode),
    .req_ready(req_ready[0]), .vsync(vsync), .vsync_pol(vsync_pol),
    .config_data(config_data[0]), .blank(blank[0]), .trigger_enable(trigger_enable[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .seq_state(seq_state[0])
  );

  mode_switch_controller #(.NUM_MODES(8), .DEFAULT_MODE(0), .SETTLE_FRAMES(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid[1]), .req_mode(req_mode),
    .req_ready(req_ready[1]), .vsync(vsync), .vsync_pol(vsync_pol),
    .config_data(config_data[1]), .blank(blank[1]), .trigger_enable(trigger_enable[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .seq_state(seq_state[1])
  );

  int n_checks = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, k, got, exp, $time);
    end
  endtask

  // frame generator: 100-clock frames, vsync active for the first 5
  int pos;
  int cyc;
  initial begin
    pos = 0;
    cyc = 0;
    vsync = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      pos = (pos == 99) ? 0 : pos + 1;
      vsync = (pos < 5) ? vsync_pol : !vsync_pol;
    end
  end

  // reference model: counts frame pulses since acceptance
  bit         m_pending[2];
  bit         m_apply[2];
  int         m_nfp[2];
  logic [7:0] m_cfg[2];
  logic [7:0] m_tgt[2];
  bit         m_blank[2];
  bit         m_done[2];
  bit         m_err[2];
  bit         m_prev[2];

  task automatic model_reset(input int k);
    m_pending[k] = 0; m_apply[k] = 0; m_nfp[k] = 0;
    m_cfg[k] = 8'd0; m_tgt[k] = 8'd0;
    m_blank[k] = 0; m_done[k] = 0; m_err[k] = 0;
    m_prev[k] = 1;
  endtask

  task automatic model_step(input int k);
    bit act;
    bit fp;
    act = (vsync == vsync_pol);
    fp = act && !m_prev[k];
    m_prev[k] = act;
    m_done[k] = 0;
    m_err[k] = 0;
    if (!m_pending[k]) begin
      if (req_valid[k]) begin
        if (int'(req_mode) >= TB_NUM_MODES) m_err[k] = 1;
        else if (req_mode == m_cfg[k]) m_done[k] = 1;
        else begin
          m_pending[k] = 1;
          m_tgt[k] = req_mode;
          m_nfp[k] = 0;
        end
      end
    end else if (m_apply[k]) begin
      m_apply[k] = 0;
      m_cfg[k] = m_tgt[k];
      if (SETTLE[k] == 0) begin
        m_pending[k] = 0; m_blank[k] = 0; m_done[k] = 1;
      end
    end else if (fp) begin
      m_nfp[k]++;
      if (m_nfp[k] == 1) m_blank[k] = 1;
      else if (m_nfp[k] == 2) m_apply[k] = 1;
      else if (m_nfp[k] == 2 + SETTLE[k]) begin
        m_pending[k] = 0; m_blank[k] = 0; m_done[k] = 1;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) model_reset(k);
    forever begin
      @(posedge clock or negedge reset_n);
      for (int k = 0; k < 2; k++) begin
        if (!reset_n) model_reset(k);
        else model_step(k);
      end
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clock) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        check("config_data", k, 32'(config_data[k]), 32'(m_cfg[k]));
        check("blank", k, 32'(blank[k]), 32'(m_blank[k]));
        check("done", k, 32'(done[k]), 32'(m_done[k]));
        check("err", k, 32'(err[k]), 32'(m_err[k]));
        check("busy", k, 32'(busy[k]), 32'(m_pending[k]));
        check("req_ready", k, 32'(req_ready[k]), 32'(!m_pending[k]));
        check("trigger_enable", k, 32'(trigger_enable[k]), 32'(!m_blank[k] && !m_pending[k]));
        check("state_idle", k, 32'(seq_state[k] == video_pkg::IDLE), 32'(!m_pending[k]));
      end
    end
  end

  // driver tasks
  task automatic wait_cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 200 && pos != p; i++) wait_cycle();
  endtask

  task automatic send_req(input logic [7:0] mode);
    req_mode = mode;
    req_valid = '{1'b1, 1'b1};
    wait_cycle();
    req_valid = '{1'b0, 1'b0};
  endtask

  int r_b[2], r_bpos[2], r_c[2], r_cpos[2], r_d[2], r_dpos[2], r_trig[2];
  logic r_dblank[2], r_pblank[2];

  task automatic run_seq(input logic [7:0] mode, input bit inject);
    logic pb[2];
    logic [7:0] pc[2];
    for (int k = 0; k < 2; k++) begin
      r_b[k] = -1; r_bpos[k] = -1; r_c[k] = -1; r_cpos[k] = -1;
      r_d[k] = -1; r_dpos[k] = -1; r_trig[k] = 0;
      r_dblank[k] = 1'b1; r_pblank[k] = 1'b0;
      pb[k] = blank[k]; pc[k] = config_data[k];
    end
    send_req(mode);
    for (int i = 0; i < 700; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (blank[k] && !pb[k] && r_b[k] < 0) begin r_b[k] = cyc; r_bpos[k] = pos; end
        if (config_data[k] !== pc[k] && r_c[k] < 0) begin r_c[k] = cyc; r_cpos[k] = pos; end
        if (done[k] && r_d[k] < 0) begin
          r_d[k] = cyc; r_dpos[k] = pos; r_dblank[k] = blank[k]; r_pblank[k] = pb[k];
        end
        if (r_d[k] < 0 && trigger_enable[k]) r_trig[k]++;
        pb[k] = blank[k];
        pc[k] = config_data[k];
      end
      if (inject && r_c[0] >= 0) begin
        if (cyc == r_c[0] + 10) begin req_mode = 8'd5; req_valid[0] = 1'b1; end
        else if (cyc == r_c[0] + 13) req_valid[0] = 1'b0;
      end
      if (r_d[0] >= 0 && r_d[1] >= 0) break;
      wait_cycle();
    end
    req_valid = '{1'b0, 1'b0};
    check("seq_completed", 0, 32'(r_d[0] >= 0 && r_d[1] >= 0), 32'd1);
  endtask

  task automatic check_seq(input logic [7:0] mode);
    check("blank_rise_pos", 0, r_bpos[0], 1);
    check("cfg_change_pos", 0, r_cpos[0], 2);
    check("cfg_after_blank", 0, r_c[0] - r_b[0], 101);
    check("done_pos", 0, r_dpos[0], 1);
    check("done_after_cfg", 0, r_d[0] - r_c[0], 199);
    check("blank_fall_with_done", 0, 32'({r_pblank[0], r_dblank[0]}), 32'd2);
    check("trigger_low", 0, r_trig[0], 0);
    check("blank_rise_pos", 1, r_bpos[1], 1);
    check("cfg_change_pos", 1, r_cpos[1], 2);
    check("done_with_cfg", 1, r_d[1] - r_c[1], 0);
    check("trigger_low", 1, r_trig[1], 0);
    check("final_cfg", 0, 32'(config_data[0]), 32'(mode));
    check("final_cfg", 1, 32'(config_data[1]), 32'(mode));
    check("model_cfg_pin", 0, 32'(m_cfg[0]), 32'(mode));
    wait_cycle();
    check("done_single", 0, 32'(done[0]), 32'd0);
  endtask

  int errs, busys, dones, blanks;

  initial begin
    req_valid = '{1'b0, 1'b0};
    req_mode = 8'd0;
    vsync_pol = 1'b1;
    wait_cycle();
    chk_on = 1'b1;
    repeat (3) wait_cycle();

    // reset release while vsync is active
    wait_pos(2);
    reset_n = 1'b1;
    wait_cycle();
    wait_cycle();
    check("rst_cfg", 0, 32'(config_data[0]), 32'd0);
    check("rst_blank", 0, 32'(blank[0]), 32'd0);
    check("rst_busy", 0, 32'(busy[0]), 32'd0);
    check("rst_ready", 0, 32'(req_ready[0]), 32'd1);
    check("rst_trig", 0, 32'(trigger_enable[0]), 32'd1);
    check("rst_done_err", 0, 32'({done[0], err[0]}), 32'd0);

    // mode 3, with mode 5 requested during SETTLE on instance 0
    wait_pos(50);
    run_seq(8'd3, 1'b1);
    check_seq(8'd3);

    // out-of-range request
    wait_pos(50);
    send_req(8'd9);
    errs = 0; busys = 0; dones = 0;
    for (int i = 0; i < 5; i++) begin
      if (err[0]) errs++;
      if (busy[0]) busys++;
      if (done[0]) dones++;
      wait_cycle();
    end
    check("err_pulse_count", 0, errs, 1);
    check("err_busy", 0, busys, 0);
    check("err_no_done", 0, dones, 0);
    check("err_cfg_kept", 0, 32'(config_data[0]), 32'd3);

    // request equal to current mode is a no-op
    send_req(8'd3);
    check("noop_done_now", 0, 32'(done[0]), 32'd1);
    check("noop_done_now", 1, 32'(done[1]), 32'd1);
    dones = 0; blanks = 0; busys = 0;
    for (int i = 0; i < 5; i++) begin
      if (done[0]) dones++;
      if (blank[0]) blanks++;
      if (busy[0]) busys++;
      wait_cycle();
    end
    check("noop_done_count", 0, dones, 1);
    check("noop_blank", 0, blanks, 0);
    check("noop_busy", 0, busys, 0);

    // reset during BLANK_FRAME
    wait_pos(50);
    send_req(8'd1);
    for (int i = 0; i < 300 && !blank[0]; i++) wait_cycle();
    repeat (10) wait_cycle();
    check("pre_reset_blank", 0, 32'(blank[0]), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_blank", 0, 32'(blank[0]), 32'd0);
    check("mid_rst_cfg", 0, 32'(config_data[0]), 32'd0);
    check("mid_rst_busy", 0, 32'(busy[0]), 32'd0);
    check("mid_rst_trig", 0, 32'(trigger_enable[0]), 32'd1);
    check("mid_rst_cfg", 1, 32'(config_data[1]), 32'd0);

    // active-low vsync
    vsync_pol = 1'b0;
    repeat (3) wait_cycle();
    wait_pos(2);
    reset_n = 1'b1;
    wait_pos(50);
    run_seq(8'd3, 1'b0);
    check_seq(8'd3);

    // randomized traffic, polarity flips and resets
    for (int i = 0; i < 4000; i++) begin
      req_valid[0] = ($urandom_range(0, 7) == 0);
      req_valid[1] = ($urandom_range(0, 7) == 0);
      req_mode = 8'($urandom_range(0, 10));
      if ($urandom_range(0, 599) == 0) vsync_pol = !vsync_pol;
      reset_n = ($urandom_range(0, 999) != 0);
      wait_cycle();
    end
    req_valid = '{1'b0, 1'b0};
    reset_n = 1'b1;
    repeat (5) wait_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
